// File: rtl/count_capture_mem.sv
// Up/down counter that records its pre-step value into a circular capture memory on every
// enabled cycle, with a registered read port and a one-cycle terminal-count pulse.
// Optional build macro COUNT_CAPTURE_ONESHOT_EN: when defined, the memory fills once and then
// freezes (wr_ptr parks at 0) until reset, while the counter keeps stepping.
module count_capture_mem #(
  parameter int unsigned      WIDTH = 8,
  parameter int unsigned      DEPTH = 16,
  parameter int unsigned      STEP  = 1,
  parameter logic [WIDTH-1:0] INIT  = '0,
  localparam int unsigned     AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] count,
  output logic [AW-1:0]    wr_ptr,
  output logic             filled,
  output logic             tc
);

  localparam logic [WIDTH-1:0] StepW   = WIDTH'(STEP);
  localparam logic [AW-1:0]    LastPtr = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic             filled_q, filled_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] term;
  logic             capture;

  // Next-state: load beats enable; tc flags a step/load landing on the direction's terminal.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    filled_d = filled_q;
    tc_d     = 1'b0;
    capture  = 1'b0;
    term     = up_down ? '1 : '0;
    if (load) begin
      count_d = load_value;
      tc_d    = (load_value == term);
    end else if (enable) begin
`ifdef COUNT_CAPTURE_ONESHOT_EN
      capture = ~filled_q;
`else
      capture = 1'b1;
`endif
      count_d = up_down ? count_q + StepW : count_q - StepW;
      tc_d    = (count_d == term);
      if (capture) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (wr_ptr_q == LastPtr) begin
          filled_d = 1'b1;
        end
      end
    end
  end

  // Control state and read register; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= INIT;
      wr_ptr_q  <= '0;
      filled_q  <= 1'b0;
      tc_q      <= 1'b0;
      rd_data_q <= '0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      filled_q  <= filled_d;
      tc_q      <= tc_d;
      rd_data_q <= mem_q[rd_addr];  // same-address write this cycle returns old data
    end
  end

  // Capture memory: contents survive reset, written with the pre-step count.
  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      mem_q[wr_ptr_q] <= count_q;
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign wr_ptr  = wr_ptr_q;
  assign filled  = filled_q;
  assign tc      = tc_q;

endmodule
